lfo_mod_delay: RTL
==================

Name: lfo_mod_delay

Overview:
- Modulated fractional delay line (vibrato/chorus core), directly downstream of the LFO generator.
- Consumes the LFO's signed 16-bit wave and new-value flag. Writes each 48 kHz audio sample into a circular buffer.
- Reads two adjacent taps at an LFO-controlled delay and linearly interpolates between them.
- Output feeds the audio output path at the same 48 kHz rate.

Parameters:
- DEPTH, 1024: buffer length in samples; power of two, at least 64.
- BASE_DELAY, 8: centre delay in whole samples; must be at least 1 and at most DEPTH-2.

Ports:
- clk  in  1  system clock (6 MHz)
- reset  in  1  asynchronous, active-low reset
- sampleIn  in  16  signed audio sample
- sampleValid  in  1  one-cycle strobe, sampleIn valid (48 kHz)
- lfoIn  in  16  signed LFO wave
- lfoValid  in  1  LFO new-value flag; lfoIn latched when high
- modDepth  in  4  modulation depth, unsigned 0..15
- sampleOut  out  16  signed delayed/interpolated sample
- outValid  out  1  one-cycle strobe, sampleOut updated
- overrun  out  1  sticky: sampleValid arrived while busy

Behaviour:
- Reset (reset low, asynchronous):
  - sampleOut=0, outValid=0, overrun=0.
  - wrPtr=0, fillCount=0, lfoLatch=0, FSM=IDLE.
  - Buffer RAM contents are not cleared.
- LFO latch: lfoLatch <= lfoIn on any cycle with lfoValid=1, independent of FSM state.
- Delay computation, in 1/64-sample units, done in WRITE:
  - offset = (lfoLatch * modDepth) >>> 9, using a signed 21-bit product and arithmetic shift.
  - delayQ = BASE_DELAY*64 + offset.
  - Clamp delayQ to the range [64, (DEPTH-2)*64].
  - D = delayQ >> 6; frac = delayQ[5:0].
- FSM states: IDLE, WRITE, RDA, RDB, CALC, OUT.
  - IDLE: on sampleValid=1, capture sampleIn and go to WRITE.
  - WRITE: buf[wrPtr] <= sample; wrPtr <= wrPtr+1 (wraps mod DEPTH); fillCount <= min(fillCount+1, DEPTH); latch D and frac.
  - RDA: issue read address (wrPtr-1-D) mod DEPTH. "wrPtr" here is the already-incremented value, so this addresses x[n-D].
  - RDB: capture tap A (synchronous RAM, 1-cycle read); issue address of x[n-D-1].
  - CALC: capture tap B.
    - If D >= fillCount, A=0. If D+1 >= fillCount, B=0. fillCount here is the updated value; unwritten or stale slots read as zero.
    - diff = B - A (17-bit signed); prod = diff * {1'b0,frac} (24-bit signed).
    - wet = A + (prod >>> 6), saturated to [-32768, 32767].
  - OUT: sampleOut <= wet; outValid=1 for exactly this cycle; return to IDLE.
- Latency: outValid is high 5 cycles after the cycle in which sampleValid was sampled high in IDLE.
- sampleValid while FSM is not IDLE: sample is dropped, overrun set to 1 and held until reset. The cycle where OUT returns to IDLE is also busy.
- frac=0 gives exactly tap A; no rounding otherwise (truncation toward -inf via arithmetic shift).
- Wrap-around: all buffer addresses are computed modulo DEPTH with no discontinuity at the wrPtr wrap.
- Reset mid-operation: the FSM aborts immediately, no outValid is emitted, and fillCount restarts at 0.

Optional Feature:
- Macro: LFO_MOD_DELAY_DRY_MIX_EN.
- Defined: in OUT, sampleOut <= (dry + wet) >>> 1 using a 17-bit sum, where dry is the captured sampleIn of the current sample (classic chorus mix).
- Undefined: sampleOut = wet only (pure vibrato).
- Latency is unchanged in both cases.

Test Plan:
- Fixed delay: DEPTH=1024, BASE_DELAY=8, modDepth=0; impulse 16'h4000 at sample 0, zeros after.
  - sampleOut=16'h4000 on the 9th output (sample index 8); all other outputs 0.
- Half-sample interpolation: lfoIn=2048 with lfoValid pulse, modDepth=8 (offset 32, delay 8.5); same impulse.
  - Outputs at indices 8 and 9 are 16'h2000; all others 0.
- Clamp: lfoIn=-32768, modDepth=15 (offset -960, clamped to 64, D=1); ramp input 0,100,200,…
  - Output n equals 100*(n-1) for n≥1; output 0 is 0 because the tap is unfilled.
- Timing/overrun: sampleValid pulses every 125 cycles → outValid exactly 5 cycles after each pulse, overrun stays 0.
  - A second sampleValid 2 cycles after the first → overrun=1 and only one outValid emitted.
- Reset mid-operation: assert reset in the RDB state → sampleOut=0, outValid=0 immediately, no pulse after release.
  - The next impulse test reproduces the fixed-delay scenario result (stale RAM is masked by fillCount).
- With LFO_MOD_DELAY_DRY_MIX_EN: fixed-delay scenario → output index 0 = 16'h2000 (dry), index 8 = 16'h2000 (wet), all others 0.

Source files
------------

// File: rtl/lfo_mod_delay.sv
// Modulated fractional delay line: circular sample buffer with two adjacent LFO-steered taps, linearly interpolated.
// Define LFO_MOD_DELAY_DRY_MIX_EN to average the dry input with the wet tap (chorus); otherwise the output is wet only (vibrato).
module lfo_mod_delay #(
  parameter int DEPTH      = 1024,
  parameter int BASE_DELAY = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sampleIn,
  input  logic               sampleValid,
  input  logic signed [15:0] lfoIn,
  input  logic               lfoValid,
  input  logic [3:0]         modDepth,
  output logic signed [15:0] sampleOut,
  output logic               outValid,
  output logic               overrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int QW    = AW + 8;
  localparam int MIN_Q = 64;
  localparam int MAX_Q = (DEPTH - 2) * 64;

  typedef enum logic [2:0] {IDLE, WRITE, RDA, RDB, CALC, OUT} state_t;

  state_t               state, stateNext;
  logic [AW-1:0]        wrPtr;
  logic [AW:0]          fillCount;
  logic signed [15:0]   lfoLatch;
  logic signed [15:0]   sampleReg;
  logic signed [15:0]   tapA;
  logic [AW-1:0]        dReg;
  logic [5:0]           fracReg;

  logic signed [15:0]   mem [DEPTH];
  logic signed [15:0]   ramQ;
  logic [AW-1:0]        addrA, addrB, rdAddr;

  logic signed [20:0]   lfoProd;
  logic signed [QW-1:0] delayQ, clampedQ;
  logic [AW-1:0]        dNext;
  logic [5:0]           fracNext;

  logic signed [15:0]   tapAEff, tapBEff;
  logic signed [16:0]   diff;
  logic signed [23:0]   prod, wetWide;
  logic signed [15:0]   wet;
  logic signed [15:0]   outNext;

  // LFO-scaled delay in 1/64-sample units, clamped so both taps stay inside the buffer.
  always_comb begin
    lfoProd  = 21'(lfoLatch) * 21'($signed({1'b0, modDepth}));
    delayQ   = QW'(BASE_DELAY * 64) + QW'(lfoProd >>> 9);
    clampedQ = delayQ;
    if (delayQ < QW'(MIN_Q))
      clampedQ = QW'(MIN_Q);
    else if (delayQ > QW'(MAX_Q))
      clampedQ = QW'(MAX_Q);
    dNext    = AW'(clampedQ >>> 6);
    fracNext = clampedQ[5:0];
  end

  // wrPtr has already advanced past the new sample, so wrPtr-1-D is x[n-D].
  assign addrA  = wrPtr - AW'(1) - dReg;
  assign addrB  = addrA - AW'(1);
  assign rdAddr = (state == RDA) ? addrA : addrB;

  always_ff @(posedge clk) begin
    if (state == WRITE)
      mem[wrPtr] <= sampleReg;
    ramQ <= mem[rdAddr];
  end

  // Taps older than the number of samples written since reset are forced to zero.
  always_comb begin
    tapAEff = ((AW+1)'(dReg) >= fillCount) ? 16'sd0 : tapA;
    tapBEff = (((AW+1)'(dReg) + (AW+1)'(1)) >= fillCount) ? 16'sd0 : ramQ;
    diff    = 17'(tapBEff) - 17'(tapAEff);
    prod    = 24'(diff) * 24'($signed({1'b0, fracReg}));
    wetWide = 24'(tapAEff) + (prod >>> 6);
    if (wetWide > 24'sd32767)
      wet = 16'sh7fff;
    else if (wetWide < -24'sd32768)
      wet = 16'sh8000;
    else
      wet = wetWide[15:0];
`ifdef LFO_MOD_DELAY_DRY_MIX_EN
    outNext = 16'((17'(sampleReg) + 17'(wet)) >>> 1);
`else
    outNext = wet;
`endif
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (sampleValid) stateNext = WRITE;
      WRITE:   stateNext = RDA;
      RDA:     stateNext = RDB;
      RDB:     stateNext = CALC;
      CALC:    stateNext = OUT;
      OUT:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // sampleOut is loaded on the CALC->OUT edge so it is valid while outValid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wrPtr     <= '0;
      fillCount <= '0;
      lfoLatch  <= '0;
      sampleReg <= '0;
      tapA      <= '0;
      dReg      <= '0;
      fracReg   <= '0;
      sampleOut <= '0;
      outValid  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state    <= stateNext;
      outValid <= (state == CALC);
      if (lfoValid)
        lfoLatch <= lfoIn;
      if (sampleValid && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sampleValid)
            sampleReg <= sampleIn;
        end
        WRITE: begin
          wrPtr   <= wrPtr + AW'(1);
          dReg    <= dNext;
          fracReg <= fracNext;
          if (fillCount != (AW+1)'(DEPTH))
            fillCount <= fillCount + (AW+1)'(1);
        end
        RDB:     tapA <= ramQ;
        CALC:    sampleOut <= outNext;
        default: ;
      endcase
    end
  end

endmodule
